// File: rtl/serial_frame_rx_if.sv
// Serial receiver bus: registered line in, received word and status strobes out.
interface serial_frame_rx_if #(
    parameter int DATA_W = 8
);
    logic              din;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              parity_err;
    logic              frame_err;
    logic              busy;

    modport master (
        output din,
        input  data_out, data_valid, parity_err, frame_err, busy
    );

    modport slave (
        input  din,
        output data_out, data_valid, parity_err, frame_err, busy
    );
endinterface

// File: rtl/serial_frame_rx.sv
// Start/data/parity/stop frame receiver on an already-registered serial line.
// Sampling points sit mid-bit, counted from the cycle the start edge was seen.
module serial_frame_rx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1
) (
    input  logic clk,
    input  logic reset,
    serial_frame_rx_if.slave bus
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int BW   = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        DONE      = 3'd5,
        WAIT_HIGH = 3'd6
    } state_t;

    state_t            state_r;
    logic [CW-1:0]     clk_cnt_r;
    logic [BW-1:0]     bit_cnt_r;
    logic [DATA_W-1:0] shift_r;
    logic              perr_r;
    logic              stop_r;
    logic [DATA_W-1:0] data_out_r;
    logic              data_valid_r;
    logic              parity_err_r;
    logic              frame_err_r;
    logic              busy_r;

    // Even parity: a set result means the data bits plus parity bit have odd weight.
    function automatic logic even_parity_err(input logic [DATA_W-1:0] d, input logic p);
        return (^d) ^ p;
    endfunction

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] s, input logic b);
        return (s >> 1) | ({{(DATA_W-1){1'b0}}, b} << (DATA_W - 1));
    endfunction

    // Receive FSM with registered outputs; strobes default low every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            clk_cnt_r    <= '0;
            bit_cnt_r    <= '0;
            shift_r      <= '0;
            perr_r       <= 1'b0;
            stop_r       <= 1'b0;
            data_out_r   <= '0;
            data_valid_r <= 1'b0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            data_valid_r <= 1'b0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (!bus.din) begin
                        state_r   <= START;
                        clk_cnt_r <= '0;
                        perr_r    <= 1'b0;
                        busy_r    <= 1'b1;
                    end else begin
                        busy_r    <= 1'b0;
                    end
                end
                START: begin
                    if (clk_cnt_r == CW'(HALF - 1)) begin
                        clk_cnt_r <= '0;
                        if (!bus.din) begin
                            state_r   <= DATA;
                            bit_cnt_r <= '0;
                        end else begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        clk_cnt_r <= clk_cnt_r + CW'(1);
                    end
                end
                DATA: begin
                    if (clk_cnt_r == CW'(CLKS_PER_BIT - 1)) begin
                        clk_cnt_r <= '0;
                        shift_r   <= shift_in(shift_r, bus.din);
                        bit_cnt_r <= bit_cnt_r + BW'(1);
                        if (bit_cnt_r == BW'(DATA_W - 1)) begin
                            state_r <= (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            state_r <= DATA;
                        end
                    end else begin
                        clk_cnt_r <= clk_cnt_r + CW'(1);
                    end
                end
                PARITY: begin
                    if (clk_cnt_r == CW'(CLKS_PER_BIT - 1)) begin
                        clk_cnt_r <= '0;
                        perr_r    <= even_parity_err(shift_r, bus.din);
                        state_r   <= STOP;
                    end else begin
                        clk_cnt_r <= clk_cnt_r + CW'(1);
                    end
                end
                STOP: begin
                    if (clk_cnt_r == CW'(CLKS_PER_BIT - 1)) begin
                        clk_cnt_r <= '0;
                        stop_r    <= bus.din;
                        state_r   <= DONE;
                    end else begin
                        clk_cnt_r <= clk_cnt_r + CW'(1);
                    end
                end
                DONE: begin
                    data_out_r   <= shift_r;
                    data_valid_r <= stop_r & ~perr_r;
                    parity_err_r <= perr_r;
                    frame_err_r  <= ~stop_r;
                    if (stop_r) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    // A held-low line must not be mistaken for a new start bit.
                    if (bus.din) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= WAIT_HIGH;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out   = data_out_r;
    assign bus.data_valid = data_valid_r;
    assign bus.parity_err = parity_err_r;
    assign bus.frame_err  = frame_err_r;
    assign bus.busy       = busy_r;
endmodule

// File: tb/tb_serial_frame_rx.sv
// Scoreboard bench: frames push expected strobes, a negedge monitor pops and compares.
module tb_serial_frame_rx;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   nstrobes = 0;

    typedef struct {
        logic [7:0] d;
        logic       v;
        logic       pe;
        logic       fe;
        int         at;
    } exp_t;

    exp_t q[$];

    serial_frame_rx_if #(.DATA_W(8)) bus ();

    serial_frame_rx #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic hold(input logic b, input int n);
        bus.din = b;
        repeat (n) @(negedge clk);
    endtask

    // Drives a full frame from a negedge; the strobe is expected 169 cycles after start detection.
    task automatic send_frame(input logic [7:0] d, input logic pb, input logic sb, input int stop_len,
                              input logic ev, input logic epe, input logic efe);
        exp_t e;
        e.d  = d;
        e.v  = ev;
        e.pe = epe;
        e.fe = efe;
        e.at = cyc + 1 + 169;
        q.push_back(e);
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(d[i], CPB);
        hold(pb, CPB);
        hold(sb, stop_len);
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && (bus.data_valid || bus.parity_err || bus.frame_err)) begin
            nstrobes++;
            if (q.size() == 0) begin
                chk("unexpected_strobe", {29'd0, bus.data_valid, bus.parity_err, bus.frame_err}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("data_out",   {24'd0, bus.data_out}, {24'd0, e.d});
                chk("data_valid", {31'd0, bus.data_valid}, {31'd0, e.v});
                chk("parity_err", {31'd0, bus.parity_err}, {31'd0, e.pe});
                chk("frame_err",  {31'd0, bus.frame_err}, {31'd0, e.fe});
                chk("strobe_cycle", cyc, e.at);
            end
        end
    end

    initial begin
        int t0;
        bus.din = 1'b1;
        reset   = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_data_out", {24'd0, bus.data_out}, 32'd0);
        chk("rst_strobes", {29'd0, bus.data_valid, bus.parity_err, bus.frame_err}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        reset = 1'b0;
        hold(1'b1, 5);

        // Good frame; stop bit cut short so busy is sampled at T+170.
        send_frame(8'hA5, 1'b0, 1'b1, 11, 1'b1, 1'b0, 1'b0);
        chk("busy_after_a5", {31'd0, bus.busy}, 32'd0);
        hold(1'b1, 10);

        send_frame(8'h3C, 1'b1, 1'b1, CPB, 1'b0, 1'b1, 1'b0);
        hold(1'b1, 10);

        // Stop bit 0 then a long low line: no retrigger while in WAIT_HIGH.
        send_frame(8'h11, 1'b0, 1'b0, CPB, 1'b0, 1'b0, 1'b1);
        hold(1'b0, 40);
        chk("busy_wait_high", {31'd0, bus.busy}, 32'd1);
        hold(1'b1, 1);
        chk("busy_released", {31'd0, bus.busy}, 32'd0);
        hold(1'b1, 10);

        // Three-cycle glitch rejected at the half-bit check.
        t0 = cyc + 1;
        hold(1'b0, 1);
        chk("busy_glitch_start", {31'd0, bus.busy}, 32'd1);
        hold(1'b0, 2);
        hold(1'b1, 7);
        chk("glitch_cycle", cyc, t0 + 9);
        chk("busy_glitch_end", {31'd0, bus.busy}, 32'd0);
        hold(1'b1, 10);

        // Asynchronous reset in the middle of data bit 4 of a 0x5A frame.
        hold(1'b0, CPB);
        for (int i = 0; i < 4; i++) hold(((8'h5A >> i) & 8'h01) != 8'h00, CPB);
        hold(1'b1, 8);
        #3;
        reset = 1'b1;
        #1;
        chk("async_data_out", {24'd0, bus.data_out}, 32'd0);
        chk("async_busy", {31'd0, bus.busy}, 32'd0);
        chk("async_strobes", {29'd0, bus.data_valid, bus.parity_err, bus.frame_err}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        hold(1'b1, 20);
        send_frame(8'h5A, 1'b0, 1'b1, CPB, 1'b1, 1'b0, 1'b0);
        hold(1'b1, 10);

        // Second start bit sampled the cycle right after DONE.
        send_frame(8'h00, 1'b0, 1'b1, 10, 1'b1, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b1, CPB, 1'b1, 1'b0, 1'b0);
        hold(1'b1, 20);

        chk("queue_empty", q.size(), 32'd0);
        chk("strobe_count", nstrobes, 32'd6);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
